// File: rtl/posit_defines.sv
// rtl/posit_defines.sv - shared posit constants, unpacked value struct and run-length helper
package posit_defines;

  localparam int NBITS        = 32;
  localparam int ES           = 2;
  localparam int FBITS        = NBITS - ES - 3;
  localparam int REGIME_CNT_W = 5;

  typedef struct packed {
    logic              sgn;
    logic signed [7:0] scale;
    logic [FBITS-1:0]  fraction;
    logic              inf;
    logic              zero;
  } value;

  // Length of the run of bits equal to x[MSB], counted from the MSB downward.
  function automatic logic [REGIME_CNT_W-1:0] posit_lzc(input logic [NBITS-2:0] x);
    logic [REGIME_CNT_W-1:0] cnt;
    logic                    done;
    cnt  = '0;
    done = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!done && (x[i] == x[NBITS-2])) begin
        cnt = cnt + REGIME_CNT_W'(1);
      end else begin
        done = 1'b1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/posit_regime_count.sv
// rtl/posit_regime_count.sv - combinational regime run-length counter over the 31 magnitude bits
module posit_regime_count
  import posit_defines::*;
(
  input  logic [NBITS-2:0]        bits_in,
  output logic [REGIME_CNT_W-1:0] run_len,
  output logic                    run_ones
);

  // Run length and polarity of the leading regime run.
  always_comb begin
    run_len  = posit_lzc(bits_in);
    run_ones = bits_in[NBITS-2];
  end

endmodule

// File: rtl/posit_extract_pipe.sv
// rtl/posit_extract_pipe.sv - two-stage valid/ready posit(32,2) to unpacked value decoder
module posit_extract_pipe
  import posit_defines::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output value             out_value,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             s1_load;
  logic             s2_load;

  logic             v1_q, v1_d;
  logic             sgn1_q, sgn1_d;
  logic [NBITS-2:0] abs1_q, abs1_d;
  logic             zero1_q, zero1_d;
  logic             inf1_q, inf1_d;

  logic             v2_q, v2_d;
  value             val2_q, val2_d;

  logic [REGIME_CNT_W-1:0] run_len;
  logic                    run_ones;
  logic [FBITS+ES-1:0]     tail;
  logic [5:0]              k;
  value                    dec;

  // Handshake: a stage advances when it is empty or the stage below advances.
  always_comb begin
    s2_load  = !v2_q || out_ready;
    s1_load  = !v1_q || s2_load;
    in_ready = s1_load;
  end

  // Stage 1 next state: sign, two's-complement magnitude and special-value flags.
  always_comb begin
    v1_d    = s1_load ? in_valid : v1_q;
    sgn1_d  = sgn1_q;
    abs1_d  = abs1_q;
    zero1_d = zero1_q;
    inf1_d  = inf1_q;
    if (s1_load && in_valid) begin
      sgn1_d  = in_data[NBITS-1];
      abs1_d  = in_data[NBITS-1] ? (~in_data[NBITS-2:0] + (NBITS-1)'(1)) : in_data[NBITS-2:0];
      zero1_d = (in_data == '0);
      inf1_d  = (in_data == {1'b1, {(NBITS-1){1'b0}}});
    end
  end

  posit_regime_count u_regime (
    .bits_in  (abs1_q),
    .run_len  (run_len),
    .run_ones (run_ones)
  );

  // Stage 2 decode: bits below the regime and its terminator start at abs[28];
  // shifting by run_len-1 left-aligns exponent then fraction, zero-filling the tail.
  always_comb begin
    tail = abs1_q[FBITS+ES-1:0] << (run_len - REGIME_CNT_W'(1));
    k    = run_ones ? ({1'b0, run_len} - 6'd1) : (6'd0 - {1'b0, run_len});
    dec  = '0;
    if (zero1_q) begin
      dec.zero = 1'b1;
    end else if (inf1_q) begin
      dec.inf = 1'b1;
    end else begin
      dec.sgn      = sgn1_q;
      dec.scale    = {k, tail[FBITS+ES-1:FBITS]};
      dec.fraction = tail[FBITS-1:0];
    end
  end

  // Stage 2 next state: output register only captures on a valid transfer from stage 1.
  always_comb begin
    v2_d   = s2_load ? v1_q : v2_q;
    val2_d = (s2_load && v1_q) ? dec : val2_q;
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      sgn1_q  <= 1'b0;
      abs1_q  <= '0;
      zero1_q <= 1'b0;
      inf1_q  <= 1'b0;
      v2_q    <= 1'b0;
      val2_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      sgn1_q  <= sgn1_d;
      abs1_q  <= abs1_d;
      zero1_q <= zero1_d;
      inf1_q  <= inf1_d;
      v2_q    <= v2_d;
      val2_q  <= val2_d;
    end
  end

  // Output view of stage 2.
  always_comb begin
    out_valid = v2_q;
    out_value = val2_q;
  end

endmodule

// File: tb/tb_posit_extract_pipe.sv
// tb/tb_posit_extract_pipe.sv - directed-vector and stream bench for posit_extract_pipe
module tb_posit_extract_pipe;
  import posit_defines::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  value        out_value;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] din;
    value        exp;
  } vec_t;

  vec_t vecs[11];
  value exp_q[$];

  posit_extract_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic value mk(logic s, logic signed [7:0] sc, logic [26:0] f, logic i, logic z);
    value r;
    r.sgn      = s;
    r.scale    = sc;
    r.fraction = f;
    r.inf      = i;
    r.zero     = z;
    return r;
  endfunction

  function automatic logic bit_at(logic [31:0] a, int i);
    return (i >= 0) ? a[i] : 1'b0;
  endfunction

  // Bit-walking reference decoder.
  function automatic value ref_decode(logic [31:0] p);
    value        r;
    logic [31:0] a;
    logic        b;
    int          i, m, k, e;
    logic [26:0] f;
    r = '0;
    if (p == 32'h0) begin
      r.zero = 1'b1;
      return r;
    end
    if (p == 32'h80000000) begin
      r.inf = 1'b1;
      return r;
    end
    r.sgn = p[31];
    a = p[31] ? -p : p;
    b = a[30];
    i = 30;
    m = 0;
    while (i >= 0 && bit_at(a, i) == b) begin
      m++;
      i--;
    end
    k = b ? (m - 1) : -m;
    i--;
    e = 0;
    repeat (2) begin
      e = e * 2 + int'(bit_at(a, i));
      i--;
    end
    f = '0;
    repeat (27) begin
      f = {f[25:0], bit_at(a, i)};
      i--;
    end
    r.scale    = 8'(4 * k + e);
    r.fraction = f;
    return r;
  endfunction

  task automatic check_value(string name, value act, value exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got sgn=%0b scale=%0d frac=%h inf=%0b zero=%0b, want sgn=%0b scale=%0d frac=%h inf=%0b zero=%0b",
               name, act.sgn, act.scale, act.fraction, act.inf, act.zero,
               exp.sgn, exp.scale, exp.fraction, exp.inf, exp.zero);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int          n_out;
    value        v0, v1, v2;

    vecs[0]  = '{32'h40000000, mk(1'b0, 8'sd0,    27'h0,       1'b0, 1'b0)};
    vecs[1]  = '{32'h00000000, mk(1'b0, 8'sd0,    27'h0,       1'b0, 1'b1)};
    vecs[2]  = '{32'h80000000, mk(1'b0, 8'sd0,    27'h0,       1'b1, 1'b0)};
    vecs[3]  = '{32'hC0000000, mk(1'b1, 8'sd0,    27'h0,       1'b0, 1'b0)};
    vecs[4]  = '{32'h48000000, mk(1'b0, 8'sd1,    27'h0,       1'b0, 1'b0)};
    vecs[5]  = '{32'h40400000, mk(1'b0, 8'sd0,    27'h0400000, 1'b0, 1'b0)};
    vecs[6]  = '{32'h7FFFFFFF, mk(1'b0, 8'sd120,  27'h0,       1'b0, 1'b0)};
    vecs[7]  = '{32'h00000001, mk(1'b0, -8'sd120, 27'h0,       1'b0, 1'b0)};
    vecs[8]  = '{32'h20000000, mk(1'b0, -8'sd4,   27'h0,       1'b0, 1'b0)};
    vecs[9]  = '{32'hFFFFFFFF, mk(1'b1, -8'sd120, 27'h0,       1'b0, 1'b0)};
    vecs[10] = '{32'h60000000, mk(1'b0, 8'sd4,    27'h0,       1'b0, 1'b0)};

    // Reset state
    repeat (2) @(negedge clk);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_value("reset out_value", out_value, '0);
    reset_n = 1'b1;
    #1;
    check_bit("idle in_ready", in_ready, 1'b1);

    // Directed table with latency check
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      in_data   = vecs[t].din;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check_bit($sformatf("vec%0d in_ready", t), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check_bit($sformatf("vec%0d early out_valid", t), out_valid, 1'b0);
      @(negedge clk);
      check_bit($sformatf("vec%0d out_valid", t), out_valid, 1'b1);
      check_value($sformatf("vec%0d %h", t, vecs[t].din), out_value, vecs[t].exp);
    end

    // Back-to-back random stream
    n_out = 0;
    for (int c = 0; c < 102; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_bit("stream extra output", out_valid, 1'b0);
        end else begin
          check_value($sformatf("stream out%0d", n_out - 1), out_value, exp_q.pop_front());
        end
      end
      if (c < 100) begin
        w        = $urandom;
        in_data  = w;
        in_valid = 1'b1;
        #1;
        if (in_ready) exp_q.push_back(ref_decode(w));
        else check_bit($sformatf("stream in_ready %0d", c), in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
    end
    check_int("stream output count", n_out, 100);
    check_int("stream leftover", exp_q.size(), 0);

    // Stall with out_ready low, then drain
    v0 = ref_decode(32'h40400000);
    v1 = ref_decode(32'hC8000000);
    v2 = ref_decode(32'h12345678);
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = 32'h40400000;
    in_valid  = 1'b1;
    #1;
    check_bit("stall in_ready w0", in_ready, 1'b1);
    @(negedge clk);
    in_data = 32'hC8000000;
    #1;
    check_bit("stall in_ready w1", in_ready, 1'b1);
    @(negedge clk);
    in_data = 32'h12345678;
    #1;
    check_bit("stall in_ready full", in_ready, 1'b0);
    check_bit("stall out_valid", out_valid, 1'b1);
    check_value("stall out w0", out_value, v0);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check_bit($sformatf("hold in_ready %0d", h), in_ready, 1'b0);
      check_value($sformatf("hold out w0 %0d", h), out_value, v0);
    end
    out_ready = 1'b1;
    #1;
    check_bit("pop+push in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_bit("drain valid w1", out_valid, 1'b1);
    check_value("drain out w1", out_value, v1);
    @(negedge clk);
    check_bit("drain valid w2", out_valid, 1'b1);
    check_value("drain out w2", out_value, v2);
    @(negedge clk);
    check_bit("drain empty", out_valid, 1'b0);

    // Asynchronous reset with a full pipeline
    out_ready = 1'b0;
    in_data   = 32'h7FFFFFFF;
    in_valid  = 1'b1;
    @(negedge clk);
    in_data = 32'h00000001;
    @(negedge clk);
    in_valid = 1'b0;
    check_bit("full before reset", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("async reset out_valid", out_valid, 1'b0);
    check_value("async reset out_value", out_value, '0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    check_bit("post reset in_ready", in_ready, 1'b1);
    check_bit("post reset no stale", out_valid, 1'b0);
    @(negedge clk);
    in_data  = 32'h48000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_bit("post reset early valid", out_valid, 1'b0);
    @(negedge clk);
    check_bit("post reset out_valid", out_valid, 1'b1);
    check_value("post reset word", out_value, mk(1'b0, 8'sd1, 27'h0, 1'b0, 1'b0));
    @(negedge clk);
    check_bit("post reset drained", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
